// File: rtl/instruction_fetch_unit.sv
// Fetch requester: issues one-word reads at fetch_pc and buffers the returned words in a prefetch FIFO for decode.
// Latency: request to if_valid is 2 edges (1-cycle memory plus FIFO write); redirect flushes everything at the edge.
// Backpressure: id_ready=0 fills the FIFO; issue stalls once buffered plus in-flight words reach BUF_DEPTH.
module instruction_fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    BUF_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd_en,
    input  logic [31:0]           mem_instr,
    input  logic                  mem_ready,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  if_valid,
    output logic [31:0]           if_instr,
    output logic [ADDR_WIDTH-1:0] if_pc,
    input  logic                  id_ready
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(BUF_DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                state;
    state_t                state_nxt;

    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] inflight_pc;
    logic                  inflight;
    logic                  drop;

    logic [CNT_W-1:0]      count;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [31:0]           buf_instr [BUF_DEPTH];
    logic [ADDR_WIDTH-1:0] buf_pc    [BUF_DEPTH];

    logic [CNT_W:0]        occupancy;
    logic                  credit_ok;
    logic                  push;
    logic                  pop;

    // In-flight word already owns a FIFO slot, so it counts against the credit.
    assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    assign credit_ok = (occupancy < DEPTH_L);

    always_comb begin
        state_nxt = state;
        mem_rd_en = 1'b0;
        case (state)
            IDLE: begin
                if (fetch_en) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                mem_rd_en = fetch_en & ~redirect_valid & credit_ok;
                if (!fetch_en) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign mem_addr = fetch_pc;

    assign if_valid = (count != '0);
    assign if_instr = if_valid ? buf_instr[rd_ptr] : 32'h0;
    assign if_pc    = if_valid ? buf_pc[rd_ptr]    : '0;

    assign push = mem_ready & inflight & ~drop & ~redirect_valid;
    assign pop  = if_valid & id_ready & ~redirect_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            drop        <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= mem_rd_en;
            drop     <= redirect_valid & inflight;
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
            end else if (mem_rd_en) begin
                fetch_pc    <= fetch_pc + ADDR_WIDTH'(1);
                inflight_pc <= fetch_pc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (redirect_valid) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            count <= count + CNT_W'(push) - CNT_W'(pop);
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Storage needs no reset: the head outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_instr[wr_ptr] <= mem_instr;
            buf_pc[wr_ptr]    <= inflight_pc;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: per-cycle vector tables plus hand sequences for redirect, stall, wrap and reset.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic [31:0] mem_addr;
    logic        mem_rd_en;
    logic [31:0] mem_instr;
    logic        mem_ready;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready = 1'b0;

    logic        mem_ready_q = 1'b0;
    logic [31:0] mem_instr_q = 32'h0;
    logic        stale_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        fe;
        logic        idr;
        logic        exp_rd;
        logic [31:0] exp_addr;
        logic        exp_vld;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t tab1 [7];
    vec_t tab2 [16];

    always #5 clk = ~clk;

    // Memory model: word i holds 0xA000_0000 + i, answered one cycle after the request.
    always @(posedge clk) begin
        mem_ready_q <= mem_rd_en;
        mem_instr_q <= 32'hA000_0000 + mem_addr;
    end
    assign mem_ready = mem_ready_q | stale_ready;
    assign mem_instr = mem_instr_q;

    instruction_fetch_unit #(
        .ADDR_WIDTH(32),
        .RESET_PC  (32'h10),
        .BUF_DEPTH (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fetch_en      (fetch_en),
        .mem_addr      (mem_addr),
        .mem_rd_en     (mem_rd_en),
        .mem_instr     (mem_instr),
        .mem_ready     (mem_ready),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .if_valid      (if_valid),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .id_ready      (id_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        stale_ready    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset if_valid",  32'(if_valid),  32'h0);
        chk("reset if_instr",  if_instr,       32'h0);
        chk("reset if_pc",     if_pc,          32'h0);
        chk("reset mem_rd_en", 32'(mem_rd_en), 32'h0);
        chk("reset mem_addr",  mem_addr,       32'h10);
        rst_n = 1'b1;
    endtask

    task automatic apply_vec(input vec_t v, input string tag, input int idx);
        fetch_en       = v.fe;
        id_ready       = v.idr;
        redirect_valid = 1'b0;
        @(negedge clk);
        chk($sformatf("%s[%0d] mem_rd_en", tag, idx), 32'(mem_rd_en), 32'(v.exp_rd));
        chk($sformatf("%s[%0d] mem_addr", tag, idx), mem_addr, v.exp_addr);
        chk($sformatf("%s[%0d] if_valid", tag, idx), 32'(if_valid), 32'(v.exp_vld));
        if (v.exp_vld) begin
            chk($sformatf("%s[%0d] if_pc", tag, idx), if_pc, v.exp_pc);
            chk($sformatf("%s[%0d] if_instr", tag, idx), if_instr, 32'hA000_0000 + v.exp_pc);
        end
        next_cycle();
    endtask

    // Waits (bounded) for the next valid head with id_ready=1 and checks it is the expected word.
    task automatic expect_pop(input logic [31:0] pc, input string tag);
        bit seen = 1'b0;
        id_ready = 1'b1;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (if_valid) begin
                seen = 1'b1;
                chk({tag, " if_pc"}, if_pc, pc);
                chk({tag, " if_instr"}, if_instr, 32'hA000_0000 + pc);
            end
            next_cycle();
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s: if_valid never rose, got none expected pc %h", tag, pc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit stalled;

        // Free-running fetch, decode always ready.
        tab1[0] = '{1'b1, 1'b1, 1'b0, 32'h10, 1'b0, 32'h0};
        tab1[1] = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b0, 32'h0};
        tab1[2] = '{1'b1, 1'b1, 1'b1, 32'h11, 1'b0, 32'h0};
        tab1[3] = '{1'b1, 1'b1, 1'b1, 32'h12, 1'b1, 32'h10};
        tab1[4] = '{1'b1, 1'b1, 1'b1, 32'h13, 1'b1, 32'h11};
        tab1[5] = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h12};
        tab1[6] = '{1'b1, 1'b1, 1'b1, 32'h15, 1'b1, 32'h13};

        // Decode stalled for 10 cycles: four words buffered, then drained in order.
        tab2[0]  = '{1'b1, 1'b0, 1'b0, 32'h10, 1'b0, 32'h0};
        tab2[1]  = '{1'b1, 1'b0, 1'b1, 32'h10, 1'b0, 32'h0};
        tab2[2]  = '{1'b1, 1'b0, 1'b1, 32'h11, 1'b0, 32'h0};
        tab2[3]  = '{1'b1, 1'b0, 1'b1, 32'h12, 1'b1, 32'h10};
        tab2[4]  = '{1'b1, 1'b0, 1'b1, 32'h13, 1'b1, 32'h10};
        tab2[5]  = '{1'b1, 1'b0, 1'b0, 32'h14, 1'b1, 32'h10};
        tab2[6]  = '{1'b1, 1'b0, 1'b0, 32'h14, 1'b1, 32'h10};
        tab2[7]  = '{1'b1, 1'b0, 1'b0, 32'h14, 1'b1, 32'h10};
        tab2[8]  = '{1'b1, 1'b0, 1'b0, 32'h14, 1'b1, 32'h10};
        tab2[9]  = '{1'b1, 1'b0, 1'b0, 32'h14, 1'b1, 32'h10};
        tab2[10] = '{1'b1, 1'b1, 1'b0, 32'h14, 1'b1, 32'h10};
        tab2[11] = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h11};
        tab2[12] = '{1'b1, 1'b1, 1'b1, 32'h15, 1'b1, 32'h12};
        tab2[13] = '{1'b1, 1'b1, 1'b1, 32'h16, 1'b1, 32'h13};
        tab2[14] = '{1'b1, 1'b1, 1'b1, 32'h17, 1'b1, 32'h14};
        tab2[15] = '{1'b1, 1'b1, 1'b1, 32'h18, 1'b1, 32'h15};

        do_reset();
        for (int i = 0; i < 7; i++) begin
            apply_vec(tab1[i], "run", i);
        end

        do_reset();
        for (int i = 0; i < 16; i++) begin
            apply_vec(tab2[i], "stall", i);
        end

        // Redirect with two buffered words (0x16, 0x17) and 0x18 in flight.
        fetch_en       = 1'b1;
        id_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        @(negedge clk);
        chk("redir head pc", if_pc, 32'h16);
        chk("redir mem_rd_en", 32'(mem_rd_en), 32'h0);
        next_cycle();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("redir flushed", 32'(if_valid), 32'h0);
        chk("redir new addr", mem_addr, 32'h200);
        chk("redir new rd_en", 32'(mem_rd_en), 32'h1);
        next_cycle();
        @(negedge clk);
        chk("redir dropped", 32'(if_valid), 32'h0);
        chk("redir addr2", mem_addr, 32'h201);
        next_cycle();
        expect_pop(32'h200, "redir pop0");
        expect_pop(32'h201, "redir pop1");

        // One-cycle fetch_en drop mid-stream.
        fetch_en = 1'b0;
        @(negedge clk);
        chk("fe_low mem_rd_en", 32'(mem_rd_en), 32'h0);
        chk("fe_low head pc", if_pc, 32'h202);
        next_cycle();
        fetch_en = 1'b1;
        expect_pop(32'h203, "fe_low inflight");
        expect_pop(32'h204, "fe_low resume");
        expect_pop(32'h205, "fe_low resume2");

        // Address wrap at the top of the space.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("wrap redir rd_en", 32'(mem_rd_en), 32'h0);
        next_cycle();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("wrap addr top", mem_addr, 32'hFFFF_FFFF);
        chk("wrap rd top", 32'(mem_rd_en), 32'h1);
        next_cycle();
        @(negedge clk);
        chk("wrap addr zero", mem_addr, 32'h0);
        chk("wrap rd zero", 32'(mem_rd_en), 32'h1);
        next_cycle();
        expect_pop(32'hFFFF_FFFF, "wrap pop top");
        expect_pop(32'h0, "wrap pop 0");
        expect_pop(32'h1, "wrap pop 1");

        // Fill to the credit limit, then reset asynchronously mid-cycle.
        id_ready = 1'b0;
        stalled  = 1'b0;
        for (int k = 0; k < 20 && !stalled; k++) begin
            @(negedge clk);
            if (!mem_rd_en) begin
                stalled = 1'b1;
            end else begin
                next_cycle();
            end
        end
        chk("rst fill stalled", 32'(stalled), 32'h1);
        chk("rst pre if_valid", 32'(if_valid), 32'h1);
        chk("rst pre head pc", if_pc, 32'h2);
        rst_n = 1'b0;
        #1;
        chk("rst async if_valid", 32'(if_valid), 32'h0);
        chk("rst async if_pc", if_pc, 32'h0);
        chk("rst async mem_addr", mem_addr, 32'h10);
        chk("rst async rd_en", 32'(mem_rd_en), 32'h0);
        next_cycle();
        rst_n       = 1'b1;
        fetch_en    = 1'b1;
        id_ready    = 1'b1;
        stale_ready = 1'b1;
        @(negedge clk);
        chk("rst stale cyc if_valid", 32'(if_valid), 32'h0);
        next_cycle();
        stale_ready = 1'b0;
        @(negedge clk);
        chk("rst no stale push", 32'(if_valid), 32'h0);
        chk("rst restart addr", mem_addr, 32'h10);
        chk("rst restart rd_en", 32'(mem_rd_en), 32'h1);
        next_cycle();
        expect_pop(32'h10, "rst pop0");
        expect_pop(32'h11, "rst pop1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
